demux14_8bit_reg: RTL and testbench
===================================

Name: demux14_8bit_reg

Overview:
- Registered 8-bit 1-to-4 demultiplexer; the distribution-side counterpart of the team's 8-bit 4:1 select mux.
- Routes one byte stream on DIN into four output holding registers A/B/C/D using the same S2/S1 select code as the mux.
- Tracks which channels were loaded in the current frame, flags a complete frame (FULL) and a double-write overrun (OVR), and clears both on ACK.
- Sits in front of the mux bank so a producer can load four operands serially and the mux can read them back in parallel.

Parameters:
- W, 8, data width of DIN and each output channel.
- RST_VAL, 0, reset and clear value of every channel register.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous reset, active-high.
- DIN  input  W  data byte to distribute.
- WE  input  1  write strobe; DIN is captured on any CLK edge where WE=1.
- S2  input  1  select bit, high half; same meaning as the mux S2.
- S1  input  1  select bit, low half; same meaning as the mux S1.
- AUTO  input  1  selects the internal round-robin pointer instead of S2/S1; functional only with AUTO_SEL_EN.
- ACK  input  1  consumer acknowledge; clears the frame state.
- A, B, C, D  output  W each  registered channel data.
- VA, VB, VC, VD  output  1 each  one-cycle pulse in the cycle the matching channel updates.
- FULL  output  1  all four channels loaded since the last ACK or reset.
- OVR  output  1  sticky overrun flag.

Behaviour:
- Reset: while RST is high, asynchronously:
  - A, B, C, D = RST_VAL.
  - VA..VD = 0, FULL = 0, OVR = 0.
  - Load mask = 0000.
  - Round-robin pointer = A.
- Channel map, mirroring the mux:
  - {S2,S1} = 11 selects A.
  - {S2,S1} = 10 selects B.
  - {S2,S1} = 01 selects C.
  - {S2,S1} = 00 selects D.
- Write: on a CLK edge with WE=1:
  - The selected channel register takes DIN.
  - The data is visible after that edge (latency 1).
  - The matching V* pulse is high for exactly that cycle.
- Channels that are not selected hold their value. WE=0 leaves all channel registers unchanged and all V* pulses low.
- Load mask: each write sets the mask bit of the selected channel. FULL is a registered flag, equal to (mask == 1111) after each edge.
- Overrun: a write to a channel whose mask bit is already set, with no ACK in the same cycle, sets OVR. OVR stays set until ACK. The data is still overwritten.
- ACK: clears the mask, FULL and OVR, and resets the pointer to A.
- ACK and WE in the same cycle: the clear happens first, then the write is counted.
  - After the edge the mask holds only the written channel's bit.
  - OVR = 0 and FULL = 0.
  - The data and V* pulse behave as a normal write.
- No reads or handshake stall: DIN is never back-pressured. Writes made while FULL=1 are accepted and raise OVR.
- Reset mid-frame: all state returns to reset values immediately; no partial frame survives.

Optional Feature:
- Macro: AUTO_SEL_EN.
- Defined:
  - With AUTO=1, the channel is taken from a 2-bit round-robin pointer, order A -> B -> C -> D -> A, and S2/S1 are ignored.
  - The pointer advances by one on each accepted WE and wraps from D to A.
  - ACK resets the pointer to A. With ACK and WE together, the write uses the pointer value before the reset, and the pointer is A after the edge.
  - With AUTO=0, S2/S1 select the channel and the pointer holds.
- Undefined:
  - The AUTO port is present but ignored; S2/S1 always select.
  - No pointer register is built.

Decomposition:
- Package demux_pkg holds:
  - Constant W_DEF = 8.
  - Enum ch_t, encoded {S2,S1}: CH_A=2'b11, CH_B=2'b10, CH_C=2'b01, CH_D=2'b00.
  - A function mapping ch_t to a one-hot mask bit.
- Sub-module demux_ch_reg: one channel register, with W/RST_VAL parameters, a load enable, and the V* pulse register. It is instantiated four times.

Test Plan:
- Reset: assert RST mid-cycle -> A..D = 00, FULL = 0, OVR = 0, V* = 0 immediately.
- Writes A, B, C, D: WE with DIN = 11, 22, 33, 44 and {S2,S1} = 11, 10, 01, 00 on consecutive cycles:
  - A=11, B=22, C=33, D=44.
  - Each V* pulses for one cycle, in order.
  - FULL=1 after the 4th edge.
- Overrun: write C=5A, then C=A5 before ACK -> C=A5, OVR=1, FULL=0. ACK -> OVR=0 and the mask is cleared.
- ACK with WE: with FULL=1, apply ACK together with WE {S2,S1}=00, DIN=77 -> D=77, FULL=0, OVR=0. Three further writes to A, B, C -> FULL=1.
- Idle: WE=0 with toggling DIN and S2/S1 -> no output changes and no V* pulses.
- AUTO_SEL_EN build: AUTO=1, six writes DIN = 01..06 with S2/S1 held at 00:
  - A=05, B=06, C=03, D=04.
  - OVR=1 after the 5th write.
  - ACK then one write -> A takes the new byte.

Source files
------------

// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the registered 1-to-4 byte demultiplexer.
//   W_DEF      : default channel data width.
//   ch_t       : channel select code, encoded exactly as {S2,S1} on the mux.
//   ch_onehot  : channel -> load-mask bit (bit0=A, bit1=B, bit2=C, bit3=D).
//   ch_next    : round-robin successor, A -> B -> C -> D -> A.
// -----------------------------------------------------------------------------
package demux_pkg;

  localparam int W_DEF = 8;

  typedef enum logic [1:0] {
    CH_D = 2'b00,
    CH_C = 2'b01,
    CH_B = 2'b10,
    CH_A = 2'b11
  } ch_t;

  function automatic logic [3:0] ch_onehot(input ch_t c);
    logic [3:0] r_bit;
    r_bit = '0;
    case (c)
      CH_A:    r_bit = 4'b0001;
      CH_B:    r_bit = 4'b0010;
      CH_C:    r_bit = 4'b0100;
      CH_D:    r_bit = 4'b1000;
      default: r_bit = '0;
    endcase
    return r_bit;
  endfunction

  function automatic ch_t ch_next(input ch_t c);
    ch_t r_n;
    r_n = CH_A;
    case (c)
      CH_A:    r_n = CH_B;
      CH_B:    r_n = CH_C;
      CH_C:    r_n = CH_D;
      CH_D:    r_n = CH_A;
      default: r_n = CH_A;
    endcase
    return r_n;
  endfunction

endpackage

// File: rtl/demux_ch_reg.sv
// -----------------------------------------------------------------------------
// demux_ch_reg
// One output channel of the demultiplexer: a holding register plus the
// one-cycle valid pulse that marks the cycle it was updated.
// Ports:
//   i_clk  : rising-edge clock
//   i_rst  : asynchronous reset, active-high
//   i_ld   : load enable (this channel selected and written)
//   i_d    : data to load
//   o_q    : registered channel data
//   o_v    : high for exactly the cycle following a load edge
// -----------------------------------------------------------------------------
module demux_ch_reg #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_ld,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q,
  output logic         o_v
);

  logic [W-1:0] r_q;
  logic         r_v;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= RST_VAL;
      r_v <= 1'b0;
    end else begin
      r_v <= i_ld;
      if (i_ld) begin
        r_q <= i_d;
      end
    end
  end

  assign o_q = r_q;
  assign o_v = r_v;

endmodule

// File: rtl/demux14_8bit_reg.sv
// -----------------------------------------------------------------------------
// demux14_8bit_reg
// Registered 8-bit 1-to-4 demultiplexer. Routes DIN into holding registers
// A/B/C/D using the {S2,S1} code of the companion 4:1 mux, tracks which
// channels were loaded in the current frame, and flags FULL and OVR until ACK.
// Optional build macro: AUTO_SEL_EN -- when defined, AUTO=1 takes the channel
// from an internal round-robin pointer (A->B->C->D->A) instead of S2/S1.
// Ports:
//   CLK, RST         : clock, asynchronous active-high reset
//   DIN [W-1:0]      : data to distribute
//   WE               : write strobe
//   S2, S1           : channel select (11=A, 10=B, 01=C, 00=D)
//   AUTO             : round-robin select (only with AUTO_SEL_EN)
//   ACK              : clear frame state (mask, FULL, OVR, pointer)
//   A, B, C, D       : registered channel data
//   VA, VB, VC, VD   : one-cycle update pulses
//   FULL             : all four channels loaded since last ACK/reset
//   OVR              : sticky double-write overrun
// -----------------------------------------------------------------------------
module demux14_8bit_reg
  import demux_pkg::*;
#(
  parameter int           W       = W_DEF,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] DIN,
  input  logic         WE,
  input  logic         S2,
  input  logic         S1,
  input  logic         AUTO,
  input  logic         ACK,
  output logic [W-1:0] A,
  output logic [W-1:0] B,
  output logic [W-1:0] C,
  output logic [W-1:0] D,
  output logic         VA,
  output logic         VB,
  output logic         VC,
  output logic         VD,
  output logic         FULL,
  output logic         OVR
);

  ch_t        w_sel;
  logic [3:0] w_wr_oh;
  logic [3:0] w_mask_base;
  logic [3:0] w_mask_nxt;
  logic       w_ovr_nxt;

  logic [3:0] r_mask;
  logic       r_full;
  logic       r_ovr;

`ifdef AUTO_SEL_EN
  ch_t r_ptr;

  // The write in an ACK cycle uses the pre-clear pointer; the pointer itself
  // returns to A.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ptr <= CH_A;
    end else if (ACK) begin
      r_ptr <= CH_A;
    end else if (WE && AUTO) begin
      r_ptr <= ch_next(r_ptr);
    end
  end

  always_comb begin
    w_sel = ch_t'({S2, S1});
    if (AUTO) begin
      w_sel = r_ptr;
    end
  end
`else
  logic w_unused_auto;
  assign w_unused_auto = AUTO;

  always_comb begin
    w_sel = ch_t'({S2, S1});
  end
`endif

  // ACK clears the frame first, then the same-cycle write is counted against
  // the cleared mask, so it can never raise OVR.
  always_comb begin
    w_wr_oh     = '0;
    w_mask_base = r_mask;
    if (WE) begin
      w_wr_oh = ch_onehot(w_sel);
    end
    if (ACK) begin
      w_mask_base = '0;
    end
    w_mask_nxt = w_mask_base | w_wr_oh;
    w_ovr_nxt  = (r_ovr & ~ACK) | (|(w_mask_base & w_wr_oh));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_mask <= '0;
      r_full <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      r_mask <= w_mask_nxt;
      r_full <= &w_mask_nxt;
      r_ovr  <= w_ovr_nxt;
    end
  end

  logic [W-1:0] w_q [4];
  logic [3:0]   w_v;

  for (genvar g = 0; g < 4; g++) begin : g_ch
    demux_ch_reg #(
      .W       (W),
      .RST_VAL (RST_VAL)
    ) u_ch (
      .i_clk (CLK),
      .i_rst (RST),
      .i_ld  (w_wr_oh[g]),
      .i_d   (DIN),
      .o_q   (w_q[g]),
      .o_v   (w_v[g])
    );
  end

  assign A    = w_q[0];
  assign B    = w_q[1];
  assign C    = w_q[2];
  assign D    = w_q[3];
  assign VA   = w_v[0];
  assign VB   = w_v[1];
  assign VC   = w_v[2];
  assign VD   = w_v[3];
  assign FULL = r_full;
  assign OVR  = r_ovr;

endmodule

// File: tb/tb_demux14_8bit_reg.sv
// -----------------------------------------------------------------------------
// tb_demux14_8bit_reg
// Self-checking bench for demux14_8bit_reg: directed frame scenarios followed
// by random traffic, checked every cycle against a behavioural model of the
// four channels, load mask, FULL, OVR and round-robin pointer.
// Honours AUTO_SEL_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_demux14_8bit_reg;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] DIN;
  logic       WE, S2, S1, AUTO, ACK;
  logic [7:0] A, B, C, D;
  logic       VA, VB, VC, VD, FULL, OVR;

  demux14_8bit_reg #(
    .W       (8),
    .RST_VAL (8'h00)
  ) dut (
    .CLK (CLK), .RST (RST), .DIN (DIN), .WE (WE), .S2 (S2), .S1 (S1),
    .AUTO (AUTO), .ACK (ACK),
    .A (A), .B (B), .C (C), .D (D),
    .VA (VA), .VB (VB), .VC (VC), .VD (VD),
    .FULL (FULL), .OVR (OVR)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Model: index 0..3 = A..D
  logic [7:0] m_ch [4];
  bit         m_v [4];
  bit         m_mask [4];
  bit         m_full, m_ovr;
  int         m_ptr;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk8({tag, ":A"}, A, m_ch[0]);
    chk8({tag, ":B"}, B, m_ch[1]);
    chk8({tag, ":C"}, C, m_ch[2]);
    chk8({tag, ":D"}, D, m_ch[3]);
    chk1({tag, ":VA"}, VA, m_v[0]);
    chk1({tag, ":VB"}, VB, m_v[1]);
    chk1({tag, ":VC"}, VC, m_v[2]);
    chk1({tag, ":VD"}, VD, m_v[3]);
    chk1({tag, ":FULL"}, FULL, m_full);
    chk1({tag, ":OVR"}, OVR, m_ovr);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_ch[i]   = 8'h00;
      m_v[i]    = 1'b0;
      m_mask[i] = 1'b0;
    end
    m_full = 1'b0;
    m_ovr  = 1'b0;
    m_ptr  = 0;
  endtask

  // One clock edge of the frame rules.
  task automatic model_edge(input bit we, input logic [7:0] din, input bit s2,
                            input bit s1, input bit auto_, input bit ack);
    int idx;
    bit use_ptr;
    use_ptr = 1'b0;
`ifdef AUTO_SEL_EN
    use_ptr = auto_;
`endif
    // {S2,S1}=3 is A (index 0) down to 0 which is D (index 3)
    idx = use_ptr ? m_ptr : 3 - (2 * int'(s2) + int'(s1));
    for (int i = 0; i < 4; i++) m_v[i] = 1'b0;
    if (ack) begin
      for (int i = 0; i < 4; i++) m_mask[i] = 1'b0;
      m_ovr = 1'b0;
    end
    if (we) begin
      if (m_mask[idx]) m_ovr = 1'b1;
      m_ch[idx]   = din;
      m_v[idx]    = 1'b1;
      m_mask[idx] = 1'b1;
    end
    if (ack) m_ptr = 0;
    else if (we && use_ptr) m_ptr = (m_ptr + 1) % 4;
    m_full = m_mask[0] && m_mask[1] && m_mask[2] && m_mask[3];
  endtask

  // Drive inputs, take one edge, check 1 time unit after it.
  task automatic cyc(input bit we, input logic [7:0] din, input bit s2, input bit s1,
                     input bit auto_, input bit ack, input string tag);
    WE = we; DIN = din; S2 = s2; S1 = s1; AUTO = auto_; ACK = ack;
    @(posedge CLK);
    model_edge(we, din, s2, s1, auto_, ack);
    #1;
    check_all(tag);
  endtask

  task automatic mid_reset(input string tag);
    #3;
    RST = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(posedge CLK);
    #1;
    check_all({tag, "_held"});
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1; DIN = '0; WE = 1'b0; S2 = 1'b0; S1 = 1'b0; AUTO = 1'b0; ACK = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_all("reset");
    RST = 1'b0;

    // Fill A, B, C, D in order
    cyc(1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0, "wrA");
    chk1("wrA_VA", VA, 1'b1);
    cyc(1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, "wrB");
    cyc(1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0, "wrC");
    cyc(1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0, "wrD");
    chk8("fill_A", A, 8'h11);
    chk8("fill_D", D, 8'h44);
    chk1("fill_FULL", FULL, 1'b1);
    chk1("fill_OVR", OVR, 1'b0);

    // Overrun on C
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "ack0");
    cyc(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, "c5a");
    chk1("c5a_OVR", OVR, 1'b0);
    cyc(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, "ca5");
    chk8("ovr_C", C, 8'hA5);
    chk1("ovr_OVR", OVR, 1'b1);
    chk1("ovr_FULL", FULL, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "ack1");
    chk1("ack1_OVR", OVR, 1'b0);
    // Mask cleared: rewriting C must not raise OVR
    cyc(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, "c3c");
    chk1("c3c_OVR", OVR, 1'b0);

    // ACK together with WE while FULL
    cyc(1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, "f2A");
    cyc(1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, "f2B");
    cyc(1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, "f2D");
    chk1("f2_FULL", FULL, 1'b1);
    cyc(1'b1, 8'h77, 1'b0, 0, 1'b0, 1'b1, "ackwe");
    chk8("ackwe_D", D, 8'h77);
    chk1("ackwe_FULL", FULL, 1'b0);
    chk1("ackwe_OVR", OVR, 1'b0);
    chk1("ackwe_VD", VD, 1'b1);
    cyc(1'b1, 8'h81, 1'b1, 1'b1, 1'b0, 1'b0, "aw_A");
    cyc(1'b1, 8'h82, 1'b1, 1'b0, 1'b0, 1'b0, "aw_B");
    cyc(1'b1, 8'h83, 1'b0, 1'b1, 1'b0, 1'b0, "aw_C");
    chk1("aw_FULL", FULL, 1'b1);
    chk1("aw_OVR", OVR, 1'b0);

    // Idle: WE low with toggling data/select
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, "idle");
    end
    chk8("idle_A", A, 8'h81);
    chk8("idle_D", D, 8'h77);

    mid_reset("rst_mid");

`ifdef AUTO_SEL_EN
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "aack");
    for (int i = 1; i <= 6; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b1, 1'b0, "auto");
      if (i == 4) chk1("auto4_OVR", OVR, 1'b0);
      if (i == 5) chk1("auto5_OVR", OVR, 1'b1);
    end
    chk8("auto_A", A, 8'h05);
    chk8("auto_B", B, 8'h06);
    chk8("auto_C", C, 8'h03);
    chk8("auto_D", D, 8'h04);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, "auto_ack");
    cyc(1'b1, 8'hE7, 1'b0, 1'b0, 1'b1, 1'b0, "auto_new");
    chk8("auto_new_A", A, 8'hE7);
    chk1("auto_new_VA", VA, 1'b1);
`endif

    // Random traffic with occasional ACK and mid-frame reset
    for (int n = 0; n < 400; n++) begin
      cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom_range(0, 7) == 0), "rnd");
      if (n % 150 == 149) mid_reset("rnd_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
